// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch controller for a multi-cycle instruction memory.
//   Owns the PC, runs the imem req/ack handshake, holds one fetched
//   instruction for the decoder, resolves the next PC from the
//   branch/jump/jal/jr controls and issues the $31 link write for jal.
//
// Build option:
//   BRANCH_DELAY_SLOT_EN - when defined, taken redirects are deferred by one
//   instruction (delay slot) through a pending-target register and the jal
//   link value becomes PC+8. When undefined, redirects are immediate and the
//   link value is PC+4.
//
// Ports:
//   Clock_i       system clock, rising edge
//   Reset_i       asynchronous reset, active low
//   imem_req_o    fetch request, held until imem_ack_i
//   imem_addr_o   fetch byte address (PC)
//   imem_ack_i    memory returns imem_rdata_i this cycle
//   imem_rdata_i  instruction word
//   stall_i       downstream hold; the latched instruction is not consumed
//   Branch_i, Zero_i, br_offset_i   beq-type redirect, signed word offset
//   Jump_i, Jal_i, jtarget_i        j / jal with 26-bit index
//   Jr_i, reg31_i                   jr $31 and the current $31 value
//   Inst_o        latched instruction
//   inst_valid_o  Inst_o holds an unconsumed instruction
//   w_reg31_o     link value (holds after the write)
//   w_reg31_we_o  one-cycle write strobe for $31
//   err_o         sticky fetch timeout
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        Branch_i,
  input  logic        Zero_i,
  input  logic [15:0] br_offset_i,
  input  logic        Jump_i,
  input  logic        Jal_i,
  input  logic        Jr_i,
  input  logic [25:0] jtarget_i,
  input  logic [31:0] reg31_i,
  output logic [31:0] Inst_o,
  output logic        inst_valid_o,
  output logic [31:0] w_reg31_o,
  output logic        w_reg31_we_o,
  output logic        err_o
);

  // state      | meaning
  // FETCH_PREP | one cycle; registers imem_req/imem_addr for the fetch
  // FETCH      | request outstanding, waiting for ack or timeout
  // EXEC       | instruction presented; consumed (and PC updated) when !stall
  // HALT       | fetch timed out; parked until reset
  localparam logic [1:0] ST_FETCH_PREP = 2'd0;
  localparam logic [1:0] ST_FETCH      = 2'd1;
  localparam logic [1:0] ST_EXEC       = 2'd2;
  localparam logic [1:0] ST_HALT       = 2'd3;

  localparam logic [3:0] WAIT_LAST = MAX_WAIT[3:0];

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] link_q, link_d;
  logic        link_we_q, link_we_d;
  logic        err_q, err_d;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] redirect_tgt;
  logic        redirect;
  logic        jal_link;
  logic [3:0]  wait_inc;

  // All PC arithmetic is plain 32-bit, so it wraps modulo 2^32.
  assign pc4      = pc_q + 32'd4;
  assign br_tgt   = pc4 + {{14{br_offset_i[15]}}, br_offset_i, 2'b00};
  assign jal_link = Jal_i & ~Jr_i;
  assign wait_inc = wait_cnt_q + 4'd1;

  // Redirect priority: jr > jal/j > taken branch.
  always_comb begin
    redirect     = 1'b1;
    redirect_tgt = pc4;
    if (Jr_i) begin
      redirect_tgt = reg31_i & 32'hFFFF_FFFC;
    end else if (Jal_i | Jump_i) begin
      redirect_tgt = {pc4[31:28], jtarget_i, 2'b00};
    end else if (Branch_i & Zero_i) begin
      redirect_tgt = br_tgt;
    end else begin
      redirect = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    link_d     = link_q;
    link_we_d  = 1'b0;
    err_d      = err_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`endif

    case (state_q)
      ST_FETCH_PREP: begin
        req_d      = 1'b1;
        addr_d     = pc_q;
        wait_cnt_d = 4'd0;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          inst_d     = imem_rdata_i;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          wait_cnt_d = 4'd0;
          state_d    = ST_EXEC;
        end else if (wait_inc == WAIT_LAST) begin
          // This was the last allowed FETCH cycle without an ack.
          err_d      = 1'b1;
          req_d      = 1'b0;
          wait_cnt_d = wait_inc;
          state_d    = ST_HALT;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      ST_EXEC: begin
        if (!stall_i) begin
          valid_d = 1'b0;
          state_d = ST_FETCH_PREP;
`ifdef BRANCH_DELAY_SLOT_EN
          if (pend_q) begin
            // Delay-slot instruction just retired; its controls are ignored.
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else begin
            pc_d = pc4;
            if (redirect) begin
              pend_d     = 1'b1;
              pend_tgt_d = redirect_tgt;
            end
            if (jal_link) begin
              link_d    = pc4 + 32'd4;
              link_we_d = 1'b1;
            end
          end
`else
          pc_d = redirect ? redirect_tgt : pc4;
          if (jal_link) begin
            link_d    = pc4;
            link_we_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q    <= ST_FETCH_PREP;
      pc_q       <= RESET_PC;
      wait_cnt_q <= 4'd0;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      inst_q     <= 32'd0;
      valid_q    <= 1'b0;
      link_q     <= 32'd0;
      link_we_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      link_q     <= link_d;
      link_we_q  <= link_we_d;
      err_q      <= err_d;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`endif

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign Inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign w_reg31_o    = link_q;
  assign w_reg31_we_o = link_we_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch, zero, jump, jal, jr;
  logic [15:0] br_offset;
  logic [25:0] jtarget;
  logic [31:0] reg31;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] w_reg31;
  logic        w_reg31_we;
  logic        err;

  fetch_sequencer dut (
    .Clock_i      (clk),
    .Reset_i      (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .stall_i      (stall),
    .Branch_i     (branch),
    .Zero_i       (zero),
    .br_offset_i  (br_offset),
    .Jump_i       (jump),
    .Jal_i        (jal),
    .Jr_i         (jr),
    .jtarget_i    (jtarget),
    .reg31_i      (reg31),
    .Inst_o       (inst),
    .inst_valid_o (inst_valid),
    .w_reg31_o    (w_reg31),
    .w_reg31_we_o (w_reg31_we),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit BDS = 1'b1;
`else
  localparam bit BDS = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          dly;
    int          stl;
    logic        br;
    logic        z;
    logic [15:0] off;
    logic        j;
    logic        jl;
    logic        r;
    logic [25:0] jt;
    logic [31:0] r31;
  } step_t;

  // scoreboard
  logic [31:0] exp_addr_q[$];
  logic        exp_we_q[$];
  logic [31:0] exp_link_q[$];

  // reference model state
  logic [31:0] m_pc, m_tgt, m_link;
  logic        m_pend;

  // observations from the last step
  logic        obs_got, obs_hold_ok, obs_stall_ok;
  logic [31:0] obs_addr, obs_inst, obs_link;
  logic        obs_v_exec, obs_v_prep, obs_we_exec, obs_we_prep, obs_we_fetch;
  int          last_req_cyc = 0, prev_req_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic step_t st(input int dly, input int stl, input logic br, input logic z,
                               input logic [15:0] off, input logic j, input logic jl,
                               input logic r, input logic [25:0] jt, input logic [31:0] r31);
    step_t s;
    s.dly = dly; s.stl = stl; s.br = br; s.z = z; s.off = off;
    s.j = j; s.jl = jl; s.r = r; s.jt = jt; s.r31 = r31;
    return s;
  endfunction

  function automatic step_t plain();
    return st(0, 0, 0, 0, 16'h0, 0, 0, 0, 26'h0, 32'h0);
  endfunction

  function automatic step_t jr_to(input logic [31:0] a);
    return st(0, 0, 0, 0, 16'h0, 0, 0, 1, 26'h0, a);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0; m_link = 32'h0;
  endtask

  task automatic model_consume(input step_t s);
    logic [31:0] pc4, tgt;
    logic        taken, we;
    pc4   = m_pc + 32'd4;
    taken = 1'b1;
    if (s.r)              tgt = {s.r31[31:2], 2'b00};
    else if (s.jl || s.j) tgt = {pc4[31:28], s.jt, 2'b00};
    else if (s.br && s.z) tgt = pc4 + ({{16{s.off[15]}}, s.off} << 2);
    else begin taken = 1'b0; tgt = pc4; end
    we = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    if (m_pend) begin
      m_pc = m_tgt; m_pend = 1'b0;
    end else begin
      if (s.jl && !s.r) begin we = 1'b1; m_link = m_pc + 32'd8; end
      if (taken) begin m_pend = 1'b1; m_tgt = tgt; end
      m_pc = pc4;
    end
`else
    if (s.jl && !s.r) begin we = 1'b1; m_link = pc4; end
    m_pc = taken ? tgt : pc4;
`endif
    exp_we_q.push_back(we);
    exp_link_q.push_back(m_link);
  endtask

  task automatic drive_idle();
    branch = 0; zero = 0; jump = 0; jal = 0; jr = 0;
    br_offset = 16'h0; jtarget = 26'h0; reg31 = 32'h0;
  endtask

  // Controls that would redirect and link if they were wrongly honoured.
  task automatic drive_junk();
    branch = 1; zero = 1; jump = 1; jal = 1; jr = 1;
    br_offset = 16'h7FFF; jtarget = 26'h3FF_FFFF; reg31 = 32'hDEAD_BEEC;
  endtask

  // Runs one fetch+consume. Entry/exit at a negedge; exit lands on the
  // first FETCH cycle of the following instruction.
  task automatic run_step(input step_t s);
    logic [31:0] i_before;
    int n;
    exp_addr_q.push_back(m_pc);
    model_consume(s);
    obs_got = 0; obs_addr = 'x; obs_inst = 'x; obs_link = 'x;
    obs_v_exec = 'x; obs_v_prep = 'x; obs_we_exec = 'x; obs_we_prep = 'x; obs_we_fetch = 'x;
    obs_hold_ok = 1; obs_stall_ok = 1;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (imem_req !== 1'b1) return;
    obs_got = 1; obs_addr = imem_addr; i_before = inst;
    prev_req_cyc = last_req_cyc; last_req_cyc = cyc;
    drive_junk();
    for (int k = 0; k < s.dly; k++) begin
      imem_ack = 0;
      imem_rdata = $urandom;
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== obs_addr || inst !== i_before || inst_valid !== 1'b0)
        obs_hold_ok = 0;
    end
    imem_ack = 1; imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack = 0; imem_rdata = $urandom;
    obs_inst = inst; obs_v_exec = inst_valid; obs_we_exec = w_reg31_we;
    for (int k = 0; k < s.stl; k++) begin
      stall = 1; drive_junk();
      @(negedge clk);
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== obs_inst || w_reg31_we !== 1'b0)
        obs_stall_ok = 0;
    end
    stall = 0;
    branch = s.br; zero = s.z; br_offset = s.off; jump = s.j;
    jal = s.jl; jr = s.r; jtarget = s.jt; reg31 = s.r31;
    @(negedge clk);
    obs_v_prep = inst_valid; obs_we_prep = w_reg31_we; obs_link = w_reg31;
    drive_idle();
    @(negedge clk);
    obs_we_fetch = w_reg31_we;
  endtask

  task automatic run_program(input string name, input step_t tbl[$]);
    logic [31:0] a, l;
    logic        w;
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      a = exp_addr_q.pop_front(); w = exp_we_q.pop_front(); l = exp_link_q.pop_front();
      n_cmp++;
      if (obs_got !== 1'b1 || obs_addr !== a) begin
        n_err++; $display("FAIL %s[%0d] fetch_addr: got %h (req seen %b) want %h", name, i, obs_addr, obs_got, a);
      end
      n_cmp++;
      if (obs_inst !== mem_word(a)) begin
        n_err++; $display("FAIL %s[%0d] inst: got %h want %h", name, i, obs_inst, mem_word(a));
      end
      n_cmp++;
      if ({obs_v_exec, obs_v_prep} !== 2'b10) begin
        n_err++; $display("FAIL %s[%0d] inst_valid exec/prep: got %b want 10", name, i, {obs_v_exec, obs_v_prep});
      end
      n_cmp++;
      if ({obs_we_exec, obs_we_prep, obs_we_fetch} !== {1'b0, w, 1'b0}) begin
        n_err++; $display("FAIL %s[%0d] w_reg31_we exec/prep/fetch: got %b want %b", name, i,
                          {obs_we_exec, obs_we_prep, obs_we_fetch}, {1'b0, w, 1'b0});
      end
      n_cmp++;
      if (obs_link !== l) begin
        n_err++; $display("FAIL %s[%0d] w_reg31: got %h want %h", name, i, obs_link, l);
      end
      if (tbl[i].dly > 0) begin
        n_cmp++;
        if (obs_hold_ok !== 1'b1) begin
          n_err++; $display("FAIL %s[%0d] req_hold: got %b want 1", name, i, obs_hold_ok);
        end
      end
      if (tbl[i].stl > 0) begin
        n_cmp++;
        if (obs_stall_ok !== 1'b1) begin
          n_err++; $display("FAIL %s[%0d] stall_hold: got %b want 1", name, i, obs_stall_ok);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1; imem_ack = 1; imem_rdata = 32'hFFFF_FFFF; stall = 0; drive_junk();
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({imem_req, inst_valid, w_reg31_we, err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags req/valid/we/err: got %b want 0000", {imem_req, inst_valid, w_reg31_we, err});
    end
    n_cmp++;
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_cmp++;
    if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_cmp++;
    if (w_reg31 !== 32'h0) begin n_err++; $display("FAIL reset_w_reg31: got %h want 0", w_reg31); end
    imem_ack = 0; drive_idle();
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_sequential();
    step_t t[$];
    repeat (3) t.push_back(plain());
    run_program("sequential", t);
    n_cmp++;
    if (last_req_cyc - prev_req_cyc !== 3) begin
      n_err++; $display("FAIL throughput cycles/instr: got %0d want 3", last_req_cyc - prev_req_cyc);
    end
  endtask

  task automatic test_wait_stall();
    step_t t[$];
    t.push_back(st(3, 5, 0, 0, 16'h0, 0, 0, 0, 26'h0, 32'h0));
    t.push_back(plain());
    run_program("wait_stall", t);
  endtask

  task automatic test_branch();
    step_t t[$];
    t.push_back(jr_to(32'h13));                                   // lands at 0x10
    if (BDS) t.push_back(plain());
    t.push_back(st(0, 0, 1, 1, 16'hFFFE, 0, 0, 0, 26'h0, 32'h0)); // 0x10 -> 0x0C
    if (BDS) t.push_back(plain());
    t.push_back(plain());                                         // 0x0C -> 0x10
    t.push_back(st(0, 0, 1, 0, 16'hFFFE, 0, 0, 0, 26'h0, 32'h0)); // not taken -> 0x14
    t.push_back(jr_to(32'h10));
    if (BDS) t.push_back(plain());
    t.push_back(st(0, 0, 1, 1, 16'h000B, 0, 0, 0, 26'h0, 32'h0)); // 0x10 -> 0x40
    if (BDS) t.push_back(st(0, 0, 0, 0, 16'h0, 1, 0, 0, 26'h155, 32'h0)); // slot controls ignored
    t.push_back(plain());
    run_program("branch", t);
  endtask

  task automatic test_jal_jr();
    step_t t[$];
    t.push_back(jr_to(32'h20));
    if (BDS) t.push_back(plain());
    t.push_back(st(0, 0, 0, 0, 16'h0, 0, 1, 0, 26'h40, 32'h0));     // jal 0x20 -> 0x100
    if (BDS) t.push_back(plain());
    t.push_back(jr_to(32'h26));                                     // -> 0x24
    if (BDS) t.push_back(plain());
    t.push_back(st(0, 2, 0, 0, 16'h0, 0, 1, 1, 26'h40, 32'h50));    // jal+jr: jr wins, no link
    if (BDS) t.push_back(plain());
    t.push_back(plain());
    run_program("jal_jr", t);
  endtask

  task automatic test_wrap();
    step_t t[$];
    t.push_back(jr_to(32'hFFFF_FFFC));
    if (BDS) t.push_back(plain());
    t.push_back(plain());                                           // 0xFFFFFFFC -> 0x0
    t.push_back(st(0, 0, 1, 1, 16'hFFFE, 0, 0, 0, 26'h0, 32'h0));   // 0x0 -> 0xFFFFFFFC
    if (BDS) t.push_back(plain());
    t.push_back(jr_to(32'h9000_0000));
    if (BDS) t.push_back(plain());
    t.push_back(st(1, 0, 0, 0, 16'h0, 1, 0, 0, 26'h3FF_FFFF, 32'h0)); // -> 0x9FFFFFFC
    if (BDS) t.push_back(plain());
    t.push_back(plain());
    run_program("wrap", t);
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    imem_ack = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      n_err++; $display("FAIL timeout_start req/addr: got %b/%h want 1/%h", imem_req, imem_addr, m_pc);
    end
    drive_junk();
    repeat (14) @(negedge clk);
    n_cmp++;
    if ({imem_req, err} !== 2'b10) begin
      n_err++; $display("FAIL timeout_15th_wait req/err: got %b want 10", {imem_req, err});
    end
    @(negedge clk);
    n_cmp++;
    if ({imem_req, err, inst_valid} !== 3'b010) begin
      n_err++; $display("FAIL timeout_halt req/err/valid: got %b want 010", {imem_req, err, inst_valid});
    end
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    repeat (5) @(negedge clk);
    imem_ack = 0; drive_idle();
    n_cmp++;
    if ({imem_req, err, inst_valid} !== 3'b010) begin
      n_err++; $display("FAIL halt_sticky req/err/valid: got %b want 010", {imem_req, err, inst_valid});
    end
  endtask

  task automatic test_reset_midwait();
    step_t t[$];
    int n;
    rst_n = 0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL reset_clears_err: got %b want 0", err); end
    rst_n = 1;
    model_reset();
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_req_drop: got %b want 0", imem_req); end
    imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({inst, inst_valid} !== 33'h0) begin
      n_err++; $display("FAIL ack_in_reset inst/valid: got %h/%b want 0/0", inst, inst_valid);
    end
    imem_ack = 0;
    rst_n = 1;
    t.push_back(plain());
    t.push_back(plain());
    run_program("restart", t);
  endtask

  initial begin
    drive_idle();
    imem_ack = 0; imem_rdata = 32'h0; stall = 0; rst_n = 1;
    test_reset();
    test_sequential();
    test_wait_stall();
    test_branch();
    test_jal_jr();
    test_wrap();
    test_timeout();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule
